seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the electric_clock multiplexed 7-seg output (SEL/SEG).
//  Watches the scanned SEL/SEG bus and reassembles full 8-digit frames: digit codes, decimal points, blanks.
//  Frames are published atomically; scan/glyph faults are flagged.
//  Synthesizable; also used as the self-checking monitor in electric_clock benches.
// PARAMETERS
//  SETTLE_CNT      16         cycles SEL/SEG must hold unchanged before a digit is captured (1..255)
//  FRAME_TMO       2_000_000  cycles allowed to collect all 8 positions (40 ms at 50 MHz)
//  SEG_ACTIVE_LOW  1          1: SEG lit = 0 (common anode); 0: lit = 1
//  SEL_ACTIVE_LOW  0          1: selected digit = 0; 0: selected digit = 1
// PORTS
//  Clk          in   1   system clock, 50 MHz
//  Reset_n      in   1   asynchronous active-low reset
//  SEL          in   8   digit select, one-hot when driving (bit i = position i, 0 = rightmost)
//  SEG          in   8   segments; SEG[7]=dp, SEG[6:0]=g..a
//  Digits       out  32  nibble i = glyph code of position i (Digits[4i+3:4i])
//  Dp           out  8   decimal point per position
//  Blank        out  8   1 = position i showed no segments (its nibble reads 4'h0)
//  Frame_valid  out  1   1-cycle pulse: Digits/Dp/Blank just updated with a complete frame
//  Frame_err    out  1   1-cycle pulse: fault detected; cause in Err_code
//  Err_code     out  2   1 = SEL not one-hot, 2 = illegal glyph, 3 = frame timeout; held until next Frame_err
// BEHAVIOUR
//  Reset: all outputs 0; capture mask, shadow regs, stability counter and timeout counter cleared.
//  Input stage: SEL/SEG registered once, normalised to active-high by parameter (s_sel, s_seg).
//  Stability: stab_cnt resets to 0 whenever {s_sel,s_seg} differs from the previous cycle.
//   Otherwise it increments, saturating at SETTLE_CNT.
//   The capture event fires in the single cycle stab_cnt reaches SETTLE_CNT: at most 1 per dwell.
//  At the capture event:
//   s_sel == 0         -> inter-digit blanking; ignored, no error.
//   s_sel not one-hot  -> Frame_err pulse, Err_code=1; mask unchanged.
//   s_sel one-hot, position p:
//    s_seg[6:0] decodes   -> shadow nibble p, dp p and blank p written; mask[p] set.
//    Re-capturing a position already in the mask overwrites it.
//    s_seg[6:0] illegal   -> Frame_err, Err_code=2; mask[p] not set.
//  Glyph table (g..a, active-high):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   blank=00 -> nibble 0, Blank=1. Any other pattern is illegal.
//  Frame completion: the cycle after mask becomes 8'hFF:
//   Digits/Dp/Blank <= shadow; Frame_valid=1; mask and timeout counter cleared.
//   Latency: the last capture is visible on the outputs 2 cycles after its capture cycle.
//  Timeout: tmo_cnt counts while mask != 0; cleared on completion.
//   At FRAME_TMO-1: Frame_err, Err_code=3, mask cleared; outputs keep the last good frame.
//  Simultaneous events: timeout and capture in the same cycle -> timeout wins, capture discarded.
//   Completion cannot coincide with an error: there is 1 capture event per cycle max.
//  Outputs change only on completion or reset; never partially updated.
//  Reset mid-frame: everything clears immediately (async); first frame after reset needs 8 fresh captures.
// TESTING
//  T1: scan 8 digits 1,2,3,4,5,6,7,8 (pos0..7), 500 cyc dwell, SEG active-low.
//   -> Frame_valid once per scan; Digits=32'h87654321, Dp=0, Blank=0.
//  T2: same scan, dp on pos2 and pos4, pos7 SEG=8'hFF (blank).
//   -> Dp=8'h14, Blank=8'h80, Digits[31:28]=0.
//  T3: dwell 10 cyc (< SETTLE_CNT) on pos3 within an otherwise good scan.
//   -> no Frame_valid until pos3 dwells >= 16; prior outputs unchanged.
//  T4: hold SEL=8'h03 for 100 cyc, then SEG=~8'h49 on pos0 -> Frame_err Err_code=1, then Err_code=2.
//  T5: scan only pos0..6, stop -> Frame_err, Err_code=3 exactly FRAME_TMO cycles after first capture; Digits unchanged.
//  T6: assert Reset_n=0 after 5 captures, release, full scan.
//   -> outputs 0 during reset; Frame_valid only after 8 new captures.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Purpose: rebuild complete 8-digit frames from a scanned SEL/SEG 7-seg bus and flag scan/glyph faults.
// Latency: 2 registered input stages + SETTLE_CNT dwell to capture; frame visible 2 cycles after its last capture.
// Backpressure: none; the bus is passively observed and frames/errors are emitted as 1-cycle pulses.
module seg_scan_decoder #(
  parameter int SETTLE_CNT     = 16,
  parameter int FRAME_TMO      = 2_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  SEL,
  input  logic [7:0]  SEG,
  output logic [31:0] Digits,
  output logic [7:0]  Dp,
  output logic [7:0]  Blank,
  output logic        Frame_valid,
  output logic        Frame_err,
  output logic [1:0]  Err_code
);

  localparam int             TW        = $clog2(FRAME_TMO + 1);
  localparam logic [7:0]     SETTLE_V  = 8'(SETTLE_CNT);
  localparam logic [7:0]     SETTLE_M1 = 8'(SETTLE_CNT - 1);
  localparam logic [TW-1:0]  TMO_M1    = TW'(FRAME_TMO - 1);

  logic [7:0]    s_sel, s_seg;        // normalised (active-high) inputs
  logic [7:0]    p_sel, p_seg;        // previous-cycle copy for change detection
  logic [7:0]    stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    mask;
  logic [7:0]    mask_nxt;
  logic [31:0]   sh_dig;
  logic [7:0]    sh_dp, sh_blank;

  logic          changed, cap_evt, sel_onehot;
  logic [2:0]    sel_pos;
  logic          glyph_ok, glyph_blank;
  logic [3:0]    glyph_nib;
  logic          tmo_hit, frame_done, cap_ok, err_sel, err_glyph;

  // Register the raw bus once and fold away the polarity parameters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s_sel <= '0;
      s_seg <= '0;
      p_sel <= '0;
      p_seg <= '0;
    end else begin
      s_sel <= SEL_ACTIVE_LOW ? ~SEL : SEL;
      s_seg <= SEG_ACTIVE_LOW ? ~SEG : SEG;
      p_sel <= s_sel;
      p_seg <= s_seg;
    end
  end

  assign changed = ({s_sel, s_seg} != {p_sel, p_seg});
  // Fires only on the step into SETTLE_CNT, so a long dwell captures once.
  assign cap_evt = !changed && (stab_cnt == SETTLE_M1);

  // Dwell counter: restarts on any bus change, saturates at the settle threshold.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                   stab_cnt <= '0;
    else if (changed)               stab_cnt <= '0;
    else if (stab_cnt != SETTLE_V)  stab_cnt <= stab_cnt + 8'd1;
  end

  // Select decode: one-hot test and position encoder.
  always_comb begin
    sel_onehot = (s_sel != 8'd0) && ((s_sel & (s_sel - 8'd1)) == 8'd0);
    sel_pos    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (s_sel[i]) sel_pos = 3'(i);
    end
  end

  // Glyph decode from g..a to hex nibble; all-dark is a legal blank.
  always_comb begin
    glyph_ok    = 1'b1;
    glyph_blank = 1'b0;
    glyph_nib   = 4'h0;
    case (s_seg[6:0])
      7'h3F: glyph_nib = 4'h0;
      7'h06: glyph_nib = 4'h1;
      7'h5B: glyph_nib = 4'h2;
      7'h4F: glyph_nib = 4'h3;
      7'h66: glyph_nib = 4'h4;
      7'h6D: glyph_nib = 4'h5;
      7'h7D: glyph_nib = 4'h6;
      7'h07: glyph_nib = 4'h7;
      7'h7F: glyph_nib = 4'h8;
      7'h6F: glyph_nib = 4'h9;
      7'h77: glyph_nib = 4'hA;
      7'h7C: glyph_nib = 4'hB;
      7'h39: glyph_nib = 4'hC;
      7'h5E: glyph_nib = 4'hD;
      7'h79: glyph_nib = 4'hE;
      7'h71: glyph_nib = 4'hF;
      7'h00: glyph_blank = 1'b1;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Event arbitration: timeout beats any capture in the same cycle.
  always_comb begin
    frame_done = (mask == 8'hFF);
    tmo_hit    = (mask != 8'd0) && !frame_done && (tmo_cnt == TMO_M1);
    cap_ok     = cap_evt && !tmo_hit && sel_onehot && glyph_ok;
    err_sel    = cap_evt && !tmo_hit && (s_sel != 8'd0) && !sel_onehot;
    err_glyph  = cap_evt && !tmo_hit && sel_onehot && !glyph_ok;
    mask_nxt   = frame_done ? 8'd0 : mask;
    if (tmo_hit)     mask_nxt = 8'd0;
    else if (cap_ok) mask_nxt[sel_pos] = 1'b1;
  end

  // Capture mask, shadow frame and collection timeout.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mask     <= '0;
      tmo_cnt  <= '0;
      sh_dig   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else begin
      mask <= mask_nxt;
      if (mask == 8'd0 || frame_done || tmo_hit) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + 1'b1;
      if (cap_ok) begin
        sh_dig[4*sel_pos +: 4] <= glyph_nib;
        sh_dp[sel_pos]         <= s_seg[7];
        sh_blank[sel_pos]      <= glyph_blank;
      end
    end
  end

  // Publish whole frames atomically and report faults with a sticky cause code.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Digits      <= '0;
      Dp          <= '0;
      Blank       <= '0;
      Frame_valid <= 1'b0;
      Frame_err   <= 1'b0;
      Err_code    <= 2'd0;
    end else begin
      Frame_valid <= frame_done;
      Frame_err   <= tmo_hit || err_sel || err_glyph;
      if (frame_done) begin
        Digits <= sh_dig;
        Dp     <= sh_dp;
        Blank  <= sh_blank;
      end
      if (tmo_hit)        Err_code <= 2'd3;
      else if (err_sel)   Err_code <= 2'd1;
      else if (err_glyph) Err_code <= 2'd2;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose: randomized and directed scan stimulus against a frame-level model of the 7-seg bus receiver.
// Latency: expectations are queued at issue time and retired whenever the DUT pulses Frame_valid/Frame_err.
// Backpressure: none; the monitor consumes every output event as it appears.
module tb_seg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int TMO    = 6000;
  localparam int LONG   = SETTLE + 10;
  localparam int SHORT  = 10;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  blank;
    int          at_cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  SEL = 8'h00;
  logic [7:0]  SEG = 8'hFF;
  logic [31:0] Digits;
  logic [7:0]  Dp, Blank;
  logic        Frame_valid, Frame_err;
  logic [1:0]  Err_code;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int drive_cyc = 0;
  int step_cyc = 0;

  exp_t        expq[$];
  logic [6:0]  gtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]  m_dig [8];
  logic [7:0]  m_dp, m_blank, m_mask;
  logic [31:0] l_dig;
  logic [7:0]  l_dp, l_blank;

  seg_scan_decoder #(
    .SETTLE_CNT(SETTLE), .FRAME_TMO(TMO), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .SEL(SEL), .SEG(SEG),
    .Digits(Digits), .Dp(Dp), .Blank(Blank),
    .Frame_valid(Frame_valid), .Frame_err(Frame_err), .Err_code(Err_code)
  );

  always #10 Clk = ~Clk;

  // Cycle count used to time the frame timeout.
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic bit is_legal(logic [6:0] g);
    bit ok = (g == 7'h00);
    for (int i = 0; i < 16; i++) if (gtab[i] == g) ok = 1'b1;
    return ok;
  endfunction

  task automatic push_err(input logic [1:0] code, input int at);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.dig = '0; e.dp = '0; e.blank = '0; e.at_cyc = at;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    m_mask = '0; m_dp = '0; m_blank = '0;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    l_dig = '0; l_dp = '0; l_blank = '0;
    expq.delete();
  endtask

  // Frame-level behaviour of one settled digit observation.
  task automatic model_capture(input logic [7:0] sel, input logic [6:0] g, input logic dp);
    int p;
    int d;
    exp_t e;
    if (sel == 8'h00) return;
    if ($countones(sel) != 1) begin push_err(2'd1, -1); return; end
    p = 0;
    for (int i = 0; i < 8; i++) if (sel[i]) p = i;
    d = -1;
    for (int i = 0; i < 16; i++) if (gtab[i] == g) d = i;
    if (g != 7'h00 && d < 0) begin push_err(2'd2, -1); return; end
    m_dig[p]   = (g == 7'h00) ? 4'h0 : d[3:0];
    m_dp[p]    = dp;
    m_blank[p] = (g == 7'h00);
    m_mask[p]  = 1'b1;
    if (m_mask == 8'hFF) begin
      e.is_err = 1'b0; e.code = '0; e.at_cyc = -1;
      for (int i = 0; i < 8; i++) e.dig[4*i +: 4] = m_dig[i];
      e.dp = m_dp; e.blank = m_blank;
      expq.push_back(e);
      l_dig = e.dig; l_dp = e.dp; l_blank = e.blank;
      m_mask = '0;
    end
  endtask

  task automatic drive(input logic [7:0] sel, input logic [7:0] lit, input int dwell);
    @(negedge Clk);
    SEL = sel;
    SEG = ~lit;
    drive_cyc = cyc;
    repeat (dwell - 1) @(negedge Clk);
  endtask

  // One digit dwell followed by a short inter-digit blanking gap.
  task automatic step(input logic [7:0] sel, input logic [6:0] g, input logic dp, input int dwell);
    if (dwell > SETTLE + 4) model_capture(sel, g, dp);
    drive(sel, {dp, g}, dwell);
    step_cyc = drive_cyc;
    drive(8'h00, 8'h00, 3);
  endtask

  task automatic rand_glyph(output logic [6:0] g, output logic dp);
    int d;
    d  = $urandom_range(0, 16);
    g  = (d == 16) ? 7'h00 : gtab[d];
    dp = 1'($urandom_range(0, 1));
  endtask

  task automatic check_held(string tag);
    chk({tag, "_digits"}, Digits, l_dig);
    chk({tag, "_dp"}, {24'd0, Dp}, {24'd0, l_dp});
    chk({tag, "_blank"}, {24'd0, Blank}, {24'd0, l_blank});
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_digits"}, Digits, 32'd0);
    chk({tag, "_dp"}, {24'd0, Dp}, 32'd0);
    chk({tag, "_blank"}, {24'd0, Blank}, 32'd0);
    chk({tag, "_valid"}, {31'd0, Frame_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, Frame_err}, 32'd0);
    chk({tag, "_code"}, {30'd0, Err_code}, 32'd0);
  endtask

  initial begin
    logic [6:0] g;
    logic       dp;
    logic [7:0] s;
    int         r;
    int         c0;
    int         budget;

    model_reset();
    fork
      // Monitor: retire one queued expectation per DUT output event.
      forever begin
        @(negedge Clk);
        if (Reset_n && Frame_err) begin
          if (expq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_frame_err: got code %0d expected no event", Err_code);
          end else begin
            chk("event_kind_err", 32'd1, {31'd0, expq[0].is_err});
            chk("err_code", {30'd0, Err_code}, {30'd0, expq[0].code});
            if (expq[0].at_cyc >= 0) chk("tmo_cycle", cyc, expq[0].at_cyc);
            void'(expq.pop_front());
          end
        end
        if (Reset_n && Frame_valid) begin
          if (expq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_frame_valid: got digits %h expected no event", Digits);
          end else begin
            chk("event_kind_frame", 32'd0, {31'd0, expq[0].is_err});
            chk("frame_digits", Digits, expq[0].dig);
            chk("frame_dp", {24'd0, Dp}, {24'd0, expq[0].dp});
            chk("frame_blank", {24'd0, Blank}, {24'd0, expq[0].blank});
            void'(expq.pop_front());
          end
        end
      end
    join_none

    // Reset state.
    repeat (5) @(negedge Clk);
    check_zero("reset");
    Reset_n = 1'b1;

    // Plain scan of 1..8, long dwell.
    for (int p = 0; p < 8; p++) step(8'(1 << p), gtab[p + 1], 1'b0, 500);

    // Decimal points on pos2/pos4, pos7 dark.
    for (int p = 0; p < 8; p++)
      step(8'(1 << p), (p == 7) ? 7'h00 : gtab[p + 1], (p == 2 || p == 4), LONG);

    // Short dwell on pos3 must not complete the frame.
    for (int p = 0; p < 8; p++) step(8'(1 << p), gtab[8 - p], 1'b0, (p == 3) ? SHORT : LONG);
    check_held("short_dwell_hold");
    step(8'h08, gtab[5], 1'b0, LONG);

    // Non-one-hot select, then an illegal glyph.
    step(8'h03, gtab[5], 1'b0, 100);
    step(8'h01, 7'h49, 1'b0, 60);

    // Partial scan then silence: timeout measured from the first capture.
    for (int p = 0; p < 7; p++) begin
      step(8'(1 << p), gtab[p + 9], 1'b0, LONG);
      if (p == 0) c0 = step_cyc;
    end
    push_err(2'd3, c0 + SETTLE + 2 + TMO);
    m_mask = '0;
    drive(8'h00, 8'h00, TMO + 60);
    check_held("timeout_hold");

    // Randomized frames with interleaved faults, short dwells and overwrites.
    for (int f = 0; f < 30; f++) begin
      for (int p = 0; p < 8; p++) begin
        r = $urandom_range(0, 99);
        if (r < 5) begin
          do s = 8'($urandom_range(0, 255)); while ($countones(s) < 2);
          rand_glyph(g, dp);
          step(s, g, dp, LONG + $urandom_range(0, 20));
        end else if (r < 10) begin
          do g = 7'($urandom_range(1, 127)); while (is_legal(g));
          step(8'(1 << p), g, 1'($urandom_range(0, 1)), LONG);
        end else if (r < 20) begin
          rand_glyph(g, dp);
          step(8'(1 << p), g, dp, $urandom_range(2, SHORT));
        end else if (r < 28 && p > 0) begin
          rand_glyph(g, dp);
          step(8'(1 << $urandom_range(0, p - 1)), g, dp, LONG);
        end
        rand_glyph(g, dp);
        step(8'(1 << p), g, dp, LONG + $urandom_range(0, 30));
      end
    end

    // Reset in the middle of a frame; a fresh full scan is needed afterwards.
    for (int p = 0; p < 5; p++) step(8'(1 << p), gtab[p], 1'b1, LONG);
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_zero("mid_frame_reset");
    Reset_n = 1'b1;
    for (int p = 0; p < 8; p++) step(8'(1 << p), gtab[15 - p], 1'b0, LONG);

    // Drain outstanding expectations, bounded.
    budget = 0;
    while (expq.size() != 0 && budget < 2000) begin
      @(negedge Clk);
      budget++;
    end
    chk("pending_expectations", expq.size(), 32'd0);
    check_held("final_outputs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
